// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue and its storage FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default instruction/PC widths, the canonical NOP encoding and
// the queue entry layout {instr, pc} at the default widths.
package fetch_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int PCLEN_DEFAULT = 10;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One queued fetch: the instruction word and the word address it came from.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0]  instr;
    logic [PCLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head is read straight from storage.
// Latency: a push is visible at dout on the cycle after it is written (no bypass).
// Backpressure: push is dropped when full without a same-cycle pop; pop is ignored when empty.
//
// Ports:
//   clk, reset    - rising-edge clock, asynchronous active-low reset
//   push, din     - write din at the tail
//   pop           - remove the head entry
//   flush         - empty the FIFO; overrides push and pop in the same cycle
//   dout          - head entry (stale data when count is 0)
//   count         - occupied entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;

  logic do_push;
  logic do_pop;
  logic is_full;
  logic is_empty;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);

  // Pop first frees the head slot, so a push into a full FIFO is fine when
  // it coincides with a pop.
  assign do_pop  = pop  && !flush && !is_empty;
  assign do_push = push && !flush && (!is_full || do_pop);

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: runs word fetches ahead of decode into a DEPTH-entry queue.
// Latency: request in cycle N, memory data in N+1, visible to decode in N+2.
// Backpressure: valid/ready toward decode; fetch stalls once queued plus in-flight reaches DEPTH.
//
// Ports:
//   clk, reset                  - rising-edge clock, asynchronous active-low reset
//   redirect, redirect_pc       - taken branch: flush everything, restart at redirect_pc
//   imem_req, imem_addr         - word fetch request to instruction memory
//   imem_rdata                  - instruction word, valid one cycle after imem_req
//   out_valid, out_ready        - head handshake with the decoder
//   out_instr, out_pc           - head instruction and its word address
//   count                       - occupied queue entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                 XLEN     = XLEN_DEFAULT,
  parameter int                 PCLEN    = PCLEN_DEFAULT,
  parameter int                 DEPTH    = 4,
  parameter logic [PCLEN-1:0]   RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [PCLEN-1:0]        redirect_pc,
  output logic                    imem_req,
  output logic [PCLEN-1:0]        imem_addr,
  input  logic [XLEN-1:0]         imem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_instr,
  output logic [PCLEN-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Same layout as fetch_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [PCLEN-1:0] pc;
  } entry_t;

  logic [PCLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [PCLEN-1:0] inflight_pc_q, inflight_pc_d;

  logic [CW-1:0]    fifo_count;
  entry_t           fifo_din;
  entry_t           fifo_dout;
  logic             push;
  logic             pop;
  logic             issue;
  logic [CW:0]      occupancy;

  assign out_valid = (fifo_count != '0);

  // A redirect cycle never pops: the whole queue is being thrown away.
  assign pop = out_valid && out_ready && !redirect;

  // Capacity is reserved at issue time, counting the outstanding response and
  // crediting a slot that a same-cycle pop frees. This is what keeps the
  // queue from ever overflowing without a full check on push.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = !redirect && (occupancy < (CW+1)'(DEPTH));

  assign imem_req  = reset && issue;
  assign imem_addr = fetch_pc_q;

  // The response of last cycle's request is enqueued unless a redirect
  // arrives together with it.
  assign push           = inflight_q && !redirect;
  assign fifo_din.instr = imem_rdata;
  assign fifo_din.pc    = inflight_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      // Word address wraps modulo 2^PCLEN.
      fetch_pc_d    = fetch_pc_q + 1'b1;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign out_instr = fifo_dout.instr;
  assign out_pc    = fifo_dout.pc;
  assign count     = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (default parameters, DEPTH=4, PCLEN=10).
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_queue;

  localparam int               XLEN     = 32;
  localparam int               PCLEN    = 10;
  localparam int               DEPTH    = 4;
  localparam int               CW       = $clog2(DEPTH) + 1;
  localparam logic [PCLEN-1:0] RESET_PC = '0;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              redirect = 1'b0;
  logic [PCLEN-1:0]  redirect_pc = '0;
  logic              imem_req;
  logic [PCLEN-1:0]  imem_addr;
  logic [XLEN-1:0]   imem_rdata = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_instr;
  logic [PCLEN-1:0]  out_pc;
  logic [CW-1:0]     count;

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  logic [PCLEN-1:0] exp_q[$];
  logic [PCLEN-1:0] nxt = RESET_PC;

  fetch_queue #(
    .XLEN     (XLEN),
    .PCLEN    (PCLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] instr_of(input logic [PCLEN-1:0] a);
    return {a, 12'h5A3, a};
  endfunction

  // One-cycle instruction memory.
  always @(posedge clk) imem_rdata <= instr_of(imem_addr);

  // Scoreboard: every observed request pushes the bench's own expected
  // address; every valid head is compared against the oldest outstanding one.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      exp_q.delete();
      nxt = RESET_PC;
    end else if (redirect) begin
      exp_q.delete();
      nxt = redirect_pc;
      tests++;
      if (imem_req !== 1'b0) begin
        fails++;
        $display("FAIL sb_redirect_req: got %b expected 0", imem_req);
      end
    end else begin
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected_head: got pc %h expected no entry", out_pc);
        end else begin
          if (out_pc !== exp_q[0] || out_instr !== instr_of(exp_q[0])) begin
            fails++;
            $display("FAIL sb_head: got pc %h instr %h expected pc %h instr %h",
                     out_pc, out_instr, exp_q[0], instr_of(exp_q[0]));
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
      if (imem_req) begin
        tests++;
        if (imem_addr !== nxt) begin
          fails++;
          $display("FAIL sb_req_addr: got %h expected %h", imem_addr, nxt);
        end
        exp_q.push_back(nxt);
        nxt = nxt + 1'b1;
      end
    end
  end

  task automatic tick(input logic rdy, input logic redir, input logic [PCLEN-1:0] rpc);
    @(negedge clk);
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic release_reset(input logic rdy);
    @(negedge clk);
    reset     = 1'b1;
    redirect  = 1'b0;
    out_ready = rdy;
    pops      = 0;
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (count !== '0)       begin fails++; $display("FAIL rst_count: got %0d expected 0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    tests++; if (out_instr !== '0)   begin fails++; $display("FAIL rst_instr: got %h expected 0", out_instr); end
    tests++; if (out_pc !== '0)      begin fails++; $display("FAIL rst_pc: got %h expected 0", out_pc); end
    tests++; if (imem_req !== 1'b0)  begin fails++; $display("FAIL rst_req: got %b expected 0", imem_req); end
  endtask

  task automatic test_stream;
    logic exp_v;
    release_reset(1'b1);
    for (int c = 0; c < 10; c++) begin
      exp_v = (c >= 2);
      tests++; if (imem_req !== 1'b1)  begin fails++; $display("FAIL stream_req c%0d: got %b expected 1", c, imem_req); end
      tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL stream_valid c%0d: got %b expected %b", c, out_valid, exp_v); end
      tick(1'b1, 1'b0, '0);
    end
    tests++; if (pops != 8) begin fails++; $display("FAIL stream_pops: got %0d expected 8", pops); end
  endtask

  task automatic test_backpressure;
    logic exp_r;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b0;
    #1;
    release_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      exp_r = (c < 4);
      tests++; if (imem_req !== exp_r) begin fails++; $display("FAIL bp_req c%0d: got %b expected %b", c, imem_req, exp_r); end
      tick(1'b0, 1'b0, '0);
    end
    tests++; if (count !== CW'(4)) begin fails++; $display("FAIL bp_full_count: got %0d expected 4", count); end
    tick(1'b1, 1'b0, '0);
    tests++; if (imem_req !== 1'b1)     begin fails++; $display("FAIL bp_pop_req: got %b expected 1", imem_req); end
    tests++; if (imem_addr !== 10'h004) begin fails++; $display("FAIL bp_pop_addr: got %h expected 004", imem_addr); end
    tests++; if (out_pc !== 10'h000)    begin fails++; $display("FAIL bp_pop_pc: got %h expected 000", out_pc); end
    tick(1'b0, 1'b0, '0);
    tests++; if (count !== CW'(3))  begin fails++; $display("FAIL bp_after_pop_count: got %0d expected 3", count); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_after_pop_req: got %b expected 0", imem_req); end
    tick(1'b0, 1'b0, '0);
    tests++; if (count !== CW'(4))  begin fails++; $display("FAIL bp_refill_count: got %0d expected 4", count); end
  endtask

  // From full, the freed slot is refilled every cycle; because the in-flight
  // word holds a reservation, occupancy settles one below DEPTH.
  task automatic test_full_pushpop;
    tick(1'b1, 1'b0, '0);
    tests++; if (count !== CW'(4))  begin fails++; $display("FAIL fpp_start_count: got %0d expected 4", count); end
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL fpp_start_req: got %b expected 1", imem_req); end
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, 1'b0, '0);
      tests++; if (count !== CW'(DEPTH-1)) begin fails++; $display("FAIL fpp_count c%0d: got %0d expected 3", c, count); end
    end
  endtask

  task automatic test_redirect;
    tick(1'b1, 1'b1, 10'h100);
    tests++; if (count !== CW'(3)) begin fails++; $display("FAIL redir_pre_count: got %0d expected 3", count); end
    tick(1'b0, 1'b0, '0);
    tests++; if (count !== '0)          begin fails++; $display("FAIL redir_count: got %0d expected 0", count); end
    tests++; if (out_valid !== 1'b0)    begin fails++; $display("FAIL redir_valid: got %b expected 0", out_valid); end
    tests++; if (imem_req !== 1'b1)     begin fails++; $display("FAIL redir_req: got %b expected 1", imem_req); end
    tests++; if (imem_addr !== 10'h100) begin fails++; $display("FAIL redir_addr: got %h expected 100", imem_addr); end
    tick(1'b0, 1'b0, '0);
    tests++; if (out_valid !== 1'b0)    begin fails++; $display("FAIL redir_stale_valid: got %b expected 0", out_valid); end
    tick(1'b1, 1'b0, '0);
    tests++; if (out_valid !== 1'b1)    begin fails++; $display("FAIL redir_first_valid: got %b expected 1", out_valid); end
    tests++; if (out_pc !== 10'h100)    begin fails++; $display("FAIL redir_first_pc: got %h expected 100", out_pc); end
  endtask

  task automatic test_back_to_back;
    logic [PCLEN-1:0] a;
    tick(1'b1, 1'b1, 10'h200);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL b2b_req0: got %b expected 0", imem_req); end
    tick(1'b1, 1'b1, 10'h3FE);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL b2b_req1: got %b expected 0", imem_req); end
    a = 10'h3FE;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, '0);
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL wrap_req i%0d: got %b expected 1", i, imem_req); end
      tests++; if (imem_addr !== a)   begin fails++; $display("FAIL wrap_addr i%0d: got %h expected %h", i, imem_addr, a); end
      a = a + 1'b1;
    end
  endtask

  task automatic test_reset_midstream;
    tick(1'b0, 1'b1, 10'h050);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL mid_redir_req: got %b expected 0", imem_req); end
    repeat (4) tick(1'b0, 1'b0, '0);
    tests++; if (count !== CW'(2)) begin fails++; $display("FAIL mid_pre_count: got %0d expected 2", count); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (count !== '0)       begin fails++; $display("FAIL mid_async_count: got %0d expected 0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
    tests++; if (imem_req !== 1'b0)  begin fails++; $display("FAIL mid_async_req: got %b expected 0", imem_req); end
    @(negedge clk);
    #3;
    release_reset(1'b1);
    tests++; if (imem_req !== 1'b1)    begin fails++; $display("FAIL mid_restart_req: got %b expected 1", imem_req); end
    tests++; if (imem_addr !== RESET_PC) begin fails++; $display("FAIL mid_restart_addr: got %h expected %h", imem_addr, RESET_PC); end
    repeat (6) tick(1'b1, 1'b0, '0);
    tests++; if (pops != 4)          begin fails++; $display("FAIL mid_pops: got %0d expected 4", pops); end
    tests++; if (out_pc !== 10'h004) begin fails++; $display("FAIL mid_head_pc: got %h expected 004", out_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pushpop();
    test_redirect();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
